// File: rtl/uart_command_initiator.sv
`timescale 1ns/1ps
// Host-side UART register-access initiator: one read/write request becomes command/data bytes,
// and a read waits (bounded) for one response byte. Define CMD_INITIATOR_RETRY_EN to retry a timed-out read once.
module uart_command_initiator #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_req_we,
    input  logic [2:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_req_ready,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_timeout,
    output logic [7:0] o_tx_data,
    output logic       o_tx_data_valid,
    input  logic       i_tx_busy,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_valid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_DATA = 3'd2,
        WAIT_RSP  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic                we_r, we_s;
    logic [7:0]          wdata_r, wdata_s;
    logic [TO_CNT_W-1:0] cnt_r, cnt_s;
    logic                ready_r, ready_s;
    logic                tx_valid_r, tx_valid_s;
    logic [7:0]          tx_data_r, tx_data_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [7:0]          rsp_rdata_r, rsp_rdata_s;
    logic                rsp_timeout_r, rsp_timeout_s;
    logic                tx_take_s;
    logic                term_s;
`ifdef CMD_INITIATOR_RETRY_EN
    logic                retry_r, retry_s;
`endif

    function automatic logic [7:0] cmd_byte(input logic [2:0] addr, input logic we);
        return {4'b0000, addr, we};
    endfunction

    assign tx_take_s = tx_valid_r & ~i_tx_busy;
    assign term_s    = (cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic; the address is captured directly into the command byte
    always_comb begin
        state_s       = state_r;
        we_s          = we_r;
        wdata_s       = wdata_r;
        cnt_s         = cnt_r;
        tx_valid_s    = tx_valid_r;
        tx_data_s     = tx_data_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = 8'h00;
        rsp_timeout_s = 1'b0;
`ifdef CMD_INITIATOR_RETRY_EN
        retry_s       = retry_r;
`endif
        case (state_r)
            IDLE: begin
                if (i_req) begin
                    state_s    = SEND_CMD;
                    we_s       = i_req_we;
                    wdata_s    = i_req_wdata;
                    tx_valid_s = 1'b1;
                    tx_data_s  = cmd_byte(i_req_addr, i_req_we);
`ifdef CMD_INITIATOR_RETRY_EN
                    retry_s    = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SEND_CMD: begin
                if (tx_take_s) begin
                    if (we_r) begin
                        state_s    = SEND_DATA;
                        tx_valid_s = 1'b1;
                        tx_data_s  = wdata_r;
                    end else begin
                        state_s    = WAIT_RSP;
                        tx_valid_s = 1'b0;
                        cnt_s      = {TO_CNT_W{1'b0}};
                    end
                end else begin
                    state_s = SEND_CMD;
                end
            end
            SEND_DATA: begin
                if (tx_take_s) begin
                    state_s     = DONE;
                    tx_valid_s  = 1'b0;
                    rsp_valid_s = 1'b1;
                end else begin
                    state_s = SEND_DATA;
                end
            end
            WAIT_RSP: begin
                // An rx strobe on the terminal-count cycle beats the timeout
                if (i_rx_data_valid) begin
                    state_s     = DONE;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = i_rx_data;
                end else if (term_s) begin
`ifdef CMD_INITIATOR_RETRY_EN
                    if (!retry_r) begin
                        // tx_data_r still holds the command byte of this read
                        state_s    = SEND_CMD;
                        retry_s    = 1'b1;
                        tx_valid_s = 1'b1;
                    end else begin
                        state_s       = DONE;
                        rsp_valid_s   = 1'b1;
                        rsp_timeout_s = 1'b1;
                    end
`else
                    state_s       = DONE;
                    rsp_valid_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
`endif
                end else begin
                    cnt_s = cnt_r + TO_CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State, request capture and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= IDLE;
            we_r          <= 1'b0;
            wdata_r       <= 8'h00;
            cnt_r         <= {TO_CNT_W{1'b0}};
            ready_r       <= 1'b1;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 8'h00;
            rsp_timeout_r <= 1'b0;
`ifdef CMD_INITIATOR_RETRY_EN
            retry_r       <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            we_r          <= we_s;
            wdata_r       <= wdata_s;
            cnt_r         <= cnt_s;
            ready_r       <= ready_s;
            tx_valid_r    <= tx_valid_s;
            tx_data_r     <= tx_data_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_timeout_r <= rsp_timeout_s;
`ifdef CMD_INITIATOR_RETRY_EN
            retry_r       <= retry_s;
`endif
        end
    end

    assign o_req_ready     = ready_r;
    assign o_tx_data_valid = tx_valid_r;
    assign o_tx_data       = tx_data_r;
    assign o_rsp_valid     = rsp_valid_r;
    assign o_rsp_rdata     = rsp_rdata_r;
    assign o_rsp_timeout   = rsp_timeout_r;

endmodule

// File: doc/uart_command_initiator.md
Name: uart_command_initiator

Overview:
Host-side initiator of the UART register-access protocol. It accepts one register read or write request at a time on a local request port and serialises it into command/data bytes for the UART transmitter. For reads it waits for the single response byte from the UART receiver, with a timeout, then returns data or a timeout status. It drives the device-side command decoder across the serial link.

Parameters:
TIMEOUT_CYCLES, 100000, cycles spent in WAIT_RSP before a read is declared timed out (>=2)
TO_CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; single clock domain, synchronous, active-high
i_req  input  1  request strobe; accepted when i_req && o_req_ready at a rising edge
i_req_we  input  1  1 = write, 0 = read
i_req_addr  input  3  register address
i_req_wdata  input  8  write data
o_req_ready  output  1  high only in IDLE
o_rsp_valid  output  1  one-cycle completion pulse
o_rsp_rdata  output  8  read data; valid with o_rsp_valid
o_rsp_timeout  output  1  read timed out; valid with o_rsp_valid
o_tx_data  output  8  byte to UART TX
o_tx_data_valid  output  1  byte present; held until accepted
i_tx_busy  input  1  UART TX busy; a byte is consumed at an edge where o_tx_data_valid=1 and i_tx_busy=0
i_rx_data  input  8  byte from UART RX
i_rx_data_valid  input  1  one-cycle strobe per received byte

Behaviour:
- Command byte encoding: {4'b0000, addr[2:0], we}. A write is followed by one data byte. A read expects exactly one response byte.
- Request fields are latched on acceptance. Later changes to the inputs are ignored.
- States and transitions:
  - IDLE -> SEND_CMD on request acceptance.
  - SEND_CMD -> SEND_DATA (we=1) or WAIT_RSP (we=0) at the edge the command byte is consumed.
  - SEND_DATA -> DONE at the edge the data byte is consumed.
  - WAIT_RSP -> DONE on i_rx_data_valid, or on timeout.
  - DONE -> IDLE after one cycle.
- Outputs per state:
  - o_tx_data_valid is registered and high throughout SEND_CMD and SEND_DATA, with o_tx_data stable.
  - o_tx_data_valid drops in the cycle after the byte is consumed. Back-to-back: the data byte is presented the cycle after the command byte is consumed.
  - o_rsp_valid=1 only in DONE. o_rsp_rdata holds the received byte for reads and 8'h00 for writes or timeouts. o_rsp_timeout=1 only for a timed-out read.
- Timeout:
  - The counter clears on WAIT_RSP entry and increments each cycle in WAIT_RSP.
  - Timeout fires when the count reaches TIMEOUT_CYCLES-1 with no rx strobe, i.e. after TIMEOUT_CYCLES cycles.
  - If the rx strobe and terminal count coincide, the rx strobe wins (data returned, timeout=0).
- Latency:
  - Write: DONE is reached 1 cycle after the data byte is consumed.
  - Minimum request-to-o_rsp_valid for a write with i_tx_busy=0 is 3 cycles.
- RX bytes arriving outside WAIT_RSP are discarded. Only the first byte in WAIT_RSP is used.
- i_req while o_req_ready=0 is ignored and is not queued.
- Reset (any time, including mid-transfer):
  - state=IDLE.
  - o_tx_data_valid, o_rsp_valid and o_rsp_timeout = 0.
  - o_tx_data and o_rsp_rdata = 8'h00; counter = 0.
  - o_req_ready=1 from the first cycle after reset.
  - A byte already handed to TX is not recalled.

Optional Feature:
CMD_INITIATOR_RETRY_EN. When defined, a read timeout does not complete immediately:
- The FSM returns to SEND_CMD and re-sends the same command byte once.
- The timeout counter is cleared for the second attempt.
- o_rsp_timeout=1 only if the second attempt also times out.
- The retry flag clears on each new request.
When undefined, the first timeout completes with o_rsp_timeout=1 and no retry logic is present.

Test Plan:
- Write addr=5, wdata=8'hA7, i_tx_busy=0 -> tx bytes 8'h0B then 8'hA7 on consecutive acceptances; o_rsp_valid pulse 3 cycles after acceptance, timeout=0, rdata=8'h00.
- Read addr=2, then inject rx byte 8'h3C 10 cycles after the command is consumed -> tx byte 8'h04; o_rsp_valid with rdata=8'h3C, timeout=0.
- Read with TIMEOUT_CYCLES=16 and no rx -> o_rsp_valid with timeout=1 exactly 16 cycles after WAIT_RSP entry (retry build: a second 8'h04 is sent, then timeout after a further 16 cycles).
- i_tx_busy held high 7 cycles during SEND_CMD -> o_tx_data_valid and o_tx_data=8'h0B held stable all 7 cycles; consumed on the first busy=0 edge.
- rx strobe on the terminal-count cycle -> data returned, timeout=0. A stray rx byte in IDLE plus i_req while busy -> both ignored, no extra tx or response.
- Assert i_rst during SEND_DATA -> the next cycle shows IDLE, all outputs at reset values, o_req_ready=1, and a new request completes normally.
